// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle between the core MEM stage (master)
// and the data-memory access unit (slave).
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory initiator: turns byte-addressed load/store requests into word-wide
// RAM strobes, with lane extraction for loads and read-modify-write for narrow stores.
module mem_access_unit #(
  parameter int DEPTH    = 128,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  io,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [63:0]       mem_address,
  output logic [63:0]       mem_write_data,
  input  logic [63:0]       mem_read_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [2:0]  off_q, off_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [63:0] mem_address_q, mem_address_d;
  logic [63:0] mem_write_data_q, mem_write_data_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_fault_q, resp_fault_d;

  function automatic logic [63:0] lane_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  logic        req_fault;
  logic [5:0]  lane_shift;
  logic [63:0] shifted, lane_val, load_ext, merged, mask_q;
  logic        sign_bit;

  assign req_fault = (|(io.req_addr[2:0] & align_mask(io.req_size))) ||
                     (io.req_addr[63:3] >= 61'(DEPTH));

  assign lane_shift = {off_q, 3'b000};
  assign mask_q     = lane_mask(size_q);
  assign shifted    = mem_read_data >> lane_shift;
  assign lane_val   = shifted & mask_q;

  always_comb begin
    sign_bit = 1'b0;
    case (size_q)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[63];
    endcase
  end

  assign load_ext = (signed_q && sign_bit) ? (lane_val | ~mask_q) : lane_val;
  // Narrow store: keep the untouched bytes of the fetched word, splice in the new lane.
  assign merged   = (mem_read_data & ~(mask_q << lane_shift)) |
                    ((wdata_q & mask_q) << lane_shift);

  always_comb begin
    state_d          = state_q;
    write_d          = write_q;
    size_d           = size_q;
    signed_d         = signed_q;
    off_d            = off_q;
    wdata_d          = wdata_q;
    cnt_d            = cnt_q;
    mem_read_d       = mem_read_q;
    mem_write_d      = mem_write_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    resp_valid_d     = resp_valid_q;
    resp_rdata_d     = resp_rdata_q;
    resp_fault_d     = resp_fault_q;

    case (state_q)
      IDLE: begin
        if (io.req_valid) begin
          write_d  = io.req_write;
          size_d   = io.req_size;
          signed_d = io.req_signed;
          off_d    = io.req_addr[2:0];
          wdata_d  = io.req_wdata;
          cnt_d    = 8'(READ_LAT - 1);
          if (req_fault) begin
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_rdata_d = '0;
            state_d      = RESP;
          end else begin
            mem_address_d = {3'b000, io.req_addr[63:3]};
            if (io.req_write && io.req_size == 2'd3) begin
              mem_write_d      = 1'b1;
              mem_write_data_d = io.req_wdata;
              state_d          = WR;
            end else begin
              mem_read_d = 1'b1;
              state_d    = RD;
            end
          end
        end
      end
      RD: begin
        if (cnt_q == 8'd0) begin
          mem_read_d = 1'b0;
          if (write_q) begin
            mem_write_d      = 1'b1;
            mem_write_data_d = merged;
            state_d          = WR;
          end else begin
            resp_valid_d = 1'b1;
            resp_rdata_d = load_ext;
            resp_fault_d = 1'b0;
            state_d      = RESP;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WR: begin
        mem_write_d  = 1'b0;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_fault_d = 1'b0;
        state_d      = RESP;
      end
      RESP: begin
        if (io.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_fault_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      write_q          <= 1'b0;
      size_q           <= 2'd0;
      signed_q         <= 1'b0;
      off_q            <= 3'd0;
      wdata_q          <= '0;
      cnt_q            <= 8'd0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= '0;
      resp_fault_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      write_q          <= write_d;
      size_q           <= size_d;
      signed_q         <= signed_d;
      off_q            <= off_d;
      wdata_q          <= wdata_d;
      cnt_q            <= cnt_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      resp_valid_q     <= resp_valid_d;
      resp_rdata_q     <= resp_rdata_d;
      resp_fault_q     <= resp_fault_d;
    end
  end

  assign io.req_ready    = (state_q == IDLE);
  assign io.resp_valid   = resp_valid_q;
  assign io.resp_rdata   = resp_rdata_q;
  assign io.resp_fault   = resp_fault_q;
  assign MEM_READ        = mem_read_q;
  assign MEM_WRITE       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_write_data  = mem_write_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit: a byte-array memory model predicts every
// response, strobe count, strobe timing and resulting RAM word.
module tb_mem_access_unit;
  localparam int DEPTH = 128;
  localparam int RL    = 3;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEM_READ, MEM_WRITE;
  logic [63:0] mem_address, mem_write_data, mem_read_data;
  logic        ram_init;

  int tests = 0;
  int fails = 0;

  mem_access_unit_if bus();

  mem_access_unit #(.DEPTH(DEPTH), .READ_LAT(RL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .io            (bus),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input int i);
    return {32'(i) * 32'h9E37_79B9, 32'(i) ^ 32'hA5A5_5A5A};
  endfunction

  // Bench-side RAM: asynchronous read, write on the rising edge of a MEM_WRITE cycle.
  logic [63:0] ram [DEPTH];
  assign mem_read_data = (mem_address < 64'(DEPTH)) ? ram[mem_address[AW-1:0]] : 64'd0;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
    end else if (MEM_WRITE && mem_address < 64'(DEPTH)) begin
      ram[mem_address[AW-1:0]] <= mem_write_data;
    end
  end

  // Reference model: plain byte array, little-endian.
  logic [7:0] mb [DEPTH*8];

  function automatic logic model_fault(input logic [63:0] addr, input logic [1:0] sz);
    return ((addr & ((64'd1 << sz) - 64'd1)) != 64'd0) || ((addr >> 3) >= 64'(DEPTH));
  endfunction

  function automatic logic [63:0] model_word(input int idx);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < 8; b++) v = v | (64'(mb[idx*8 + b]) << (8*b));
    return v;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [1:0] sz,
                                             input logic sg);
    logic [63:0] v;
    int n, ba;
    n  = 1 << sz;
    ba = int'(addr[AW+2:0]);
    v  = '0;
    for (int i = 0; i < n; i++) v = v | (64'(mb[ba + i]) << (8*i));
    if (sg && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Every cycle out of reset: the two strobes are exclusive, faults carry zero data.
  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if ((MEM_READ && MEM_WRITE) || (bus.resp_valid && bus.resp_fault && bus.resp_rdata != 0)) begin
        fails++;
        $display("FAIL strobe_excl: rd=%0b wr=%0b fault=%0b rdata=0x%h", MEM_READ, MEM_WRITE,
                 bus.resp_fault, bus.resp_rdata);
      end
    end
  end

  task automatic scramble_req();
    bus.req_write  = 1'($urandom);
    bus.req_size   = 2'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_addr   = {$urandom, $urandom};
    bus.req_wdata  = {$urandom, $urandom};
  endtask

  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [63:0] addr, input logic [63:0] wd, input int hold,
                         output logic [63:0] got, output logic got_flt);
    logic [63:0] exp_rd, exp_word, held;
    logic        exp_flt;
    int exp_lat, exp_rds, exp_wrs, exp_frd, exp_fwr, lat, rds, wrs, frd, fwr, idx, off;
    exp_flt  = model_fault(addr, sz);
    idx      = exp_flt ? 0 : int'(addr[AW+2:3]);
    off      = int'(addr[2:0]);
    exp_rd   = 64'd0;
    exp_word = model_word(idx);
    exp_rds  = 0; exp_wrs = 0; exp_frd = 0; exp_fwr = 0;
    if (exp_flt) begin
      exp_lat = 1;
    end else if (!w) begin
      exp_rd = model_load(addr, sz, sg);
      exp_lat = RL + 1; exp_rds = RL; exp_frd = 1;
    end else begin
      for (int i = 0; i < (1 << sz); i++) exp_word[8*(off+i) +: 8] = wd[8*i +: 8];
      if (sz == 2'd3) begin
        exp_lat = 2; exp_wrs = 1; exp_fwr = 1;
      end else begin
        exp_lat = RL + 2; exp_rds = RL; exp_wrs = 1; exp_frd = 1; exp_fwr = RL + 1;
      end
    end

    @(negedge clk);
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz; bus.req_signed = sg;
    bus.req_addr = addr; bus.req_wdata = wd; bus.resp_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    scramble_req();

    lat = -1; rds = 0; wrs = 0; frd = 0; fwr = 0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (MEM_READ) begin
        rds++;
        if (frd == 0) frd = c;
      end
      if (MEM_WRITE) begin
        wrs++;
        if (fwr == 0) fwr = c;
        chk("mem_write_data", mem_write_data, exp_word);
      end
      if (MEM_READ || MEM_WRITE) chk("mem_address", mem_address, addr >> 3);
      if (bus.resp_valid) lat = c;
    end
    if (lat < 0) begin
      tests++; fails++;
      $display("FAIL resp_timeout: no resp_valid within 40 cycles for addr 0x%h", addr);
    end
    chk("resp_latency", 64'(lat), 64'(exp_lat));
    chk("read_cycles", 64'(rds), 64'(exp_rds));
    chk("write_cycles", 64'(wrs), 64'(exp_wrs));
    chk("first_read_cycle", 64'(frd), 64'(exp_frd));
    chk("first_write_cycle", 64'(fwr), 64'(exp_fwr));
    chk("resp_fault", 64'(bus.resp_fault), 64'(exp_flt));
    chk("resp_rdata", bus.resp_rdata, exp_rd);
    got = bus.resp_rdata; got_flt = bus.resp_fault; held = bus.resp_rdata;

    // Stall the consumer while offering a stray request that must be ignored.
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd3;
      bus.req_addr = {51'd0, 7'($urandom), 3'd0}; bus.req_wdata = {$urandom, $urandom};
      @(negedge clk);
      chk("hold_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("hold_resp_rdata", bus.resp_rdata, held);
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
      chk("hold_no_strobe", 64'(MEM_READ | MEM_WRITE), 64'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("post_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("post_req_ready", 64'(bus.req_ready), 64'd1);

    if (w && !exp_flt) begin
      for (int i = 0; i < (1 << sz); i++) mb[idx*8 + off + i] = wd[8*i +: 8];
      chk("ram_word", ram[idx], model_word(idx));
    end
    $display("[TB] txn w=%0b sz=%0d sg=%0b addr=0x%h wdata=0x%h -> fault=%0b rdata=0x%h lat=%0d",
             w, sz, sg, addr, wd, got_flt, got, lat);
  endtask

  logic [63:0] got;
  logic        gflt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w0, addr;
    logic [2:0]  off;
    logic [1:0]  sz;
    int          idx;

    rst_n = 1'b0; ram_init = 1'b1;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
    scramble_req();
    for (int i = 0; i < DEPTH; i++) begin
      w0 = init_word(i);
      for (int b = 0; b < 8; b++) mb[i*8 + b] = w0[8*b +: 8];
    end
    @(posedge clk); @(posedge clk);
    #1;
    ram_init = 1'b0;
    chk("rst_mem_read", 64'(MEM_READ), 64'd0);
    chk("rst_mem_write", 64'(MEM_WRITE), 64'd0);
    chk("rst_mem_address", mem_address, 64'd0);
    chk("rst_mem_wdata", mem_write_data, 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst_resp_fault", 64'(bus.resp_fault), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios with hand-computed values.
    run_req(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122_3344_5566_7788, 0, got, gflt);
    run_req(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 0, got, gflt);
    chk("lit_load_dword", got, 64'h1122_3344_5566_7788);
    run_req(1'b1, 2'd0, 1'b0, 64'h13, 64'hAB, 0, got, gflt);
    chk("lit_rmw_word", ram[2], 64'h1122_3344_AB66_7788);
    run_req(1'b0, 2'd0, 1'b1, 64'h13, 64'h0, 5, got, gflt);
    chk("lit_load_byte_s", got, 64'hFFFF_FFFF_FFFF_FFAB);
    run_req(1'b0, 2'd0, 1'b0, 64'h13, 64'h0, 0, got, gflt);
    chk("lit_load_byte_u", got, 64'h0000_0000_0000_00AB);
    run_req(1'b0, 2'd1, 1'b0, 64'h11, 64'h0, 0, got, gflt);
    chk("lit_fault_misalign", 64'(gflt), 64'd1);
    run_req(1'b0, 2'd2, 1'b0, 64'h404, 64'h0, 0, got, gflt);
    chk("lit_fault_range", 64'(gflt), 64'd1);
    run_req(1'b1, 2'd3, 1'b0, 64'(DEPTH*8 - 8), 64'hDEAD_BEEF_0BAD_F00D, 0, got, gflt);
    chk("lit_last_word", ram[DEPTH-1], 64'hDEAD_BEEF_0BAD_F00D);

    // Reset in the middle of a read-modify-write: no write, no response.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = 64'h21; bus.req_wdata = 64'h5A;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_reading", 64'(MEM_READ), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_read_drop", 64'(MEM_READ), 64'd0);
    chk("rstmid_write_drop", 64'(MEM_WRITE), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rstmid_no_resp", 64'(bus.resp_valid), 64'd0);
      chk("rstmid_no_write", 64'(MEM_WRITE), 64'd0);
    end
    chk("rstmid_ram", ram[4], model_word(4));
    $display("[TB] txn reset during RMW at addr 0x21 checked");

    // Randomised traffic, concentrated on a few words so loads observe earlier stores.
    for (int t = 0; t < 150; t++) begin
      sz  = 2'($urandom_range(0, 3));
      idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7))
                                        : int'($urandom_range(0, DEPTH + 1));
      off = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) off = off & ~3'((1 << sz) - 1);
      addr = {61'(idx), off};
      if ($urandom_range(0, 19) == 0) addr[63] = 1'b1;
      run_req(1'($urandom), sz, 1'($urandom), addr, {$urandom, $urandom},
              int'($urandom_range(0, 2)), got, gflt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
